// File: rtl/spi_sram_responder_if.sv
// Word-request bus between the memory controller and the SPI SRAM responder.
// The controller side drives requests; the responder side returns ready and read data.
interface spi_sram_responder_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/spi_sram_responder.sv
// Runs one 16-bit word request at a time as a 48-bit SPI mode-0 frame to a
// 23LC1024-class SRAM: cmd byte, 24-bit byte address, 16 data bits, MSB first.
module spi_sram_responder #(
    parameter int CLK_DIV = 2,  // clk cycles per SCK half-period
    parameter int CS_GAP  = 2   // clk cycles of cs_n high after a frame
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_sram_responder_if.slave  mem,
    output logic                 spi_sck,
    output logic                 spi_cs_n,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [7:0]  CMD_WRITE = 8'h02;
    localparam logic [7:0]  CMD_READ  = 8'h03;
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
    localparam logic [5:0]  LAST_BIT  = 6'd47;
    localparam logic [5:0]  DATA_BIT0 = 6'd32;

    state_t      state;
    logic [15:0] cnt;        // cycles spent in the current SETUP/HOLD period or SCK half
    logic [5:0]  bit_idx;    // frame bit currently on MOSI, 0 = MSB of the command
    logic [47:0] tx_sr;      // bit 47 is the bit currently driven on MOSI
    logic [15:0] rx_sr;
    logic        we_q;
    logic        ready_q;
    logic [15:0] rdata_q;
    logic        rvalid_q;
    logic [47:0] load_frame;

    // Frame image built from the live request inputs; captured only on acceptance.
    // Word address becomes byte address {7'b0, addr, 1'b0}; reads shift out zeros in the data field.
    assign load_frame = {(mem.mem_we ? CMD_WRITE : CMD_READ), 7'b0, mem.mem_addr, 1'b0,
                         (mem.mem_we ? mem.mem_wdata : 16'h0000)};

    assign mem.mem_ready  = ready_q;
    assign mem.mem_rdata  = rdata_q;
    assign mem.mem_rvalid = rvalid_q;

    // Frame sequencer: every output is a register so the pads see glitch-free SPI signals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            we_q     <= 1'b0;
            ready_q  <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            spi_sck  <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here, so every branch reads the pre-edge values
            // (e.g. tx_sr[46] below is the bit before this edge's shift) -- order of statements does not matter.
            rvalid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem.mem_req) begin
                        we_q     <= mem.mem_we;
                        tx_sr    <= load_frame;
                        spi_mosi <= load_frame[47];
                        ready_q  <= 1'b0;
                        spi_cs_n <= 1'b0;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + 16'd1;
                    end else begin
                        cnt <= '0;
                        if (!spi_sck) begin
                            // End of low half: raise SCK and capture MISO for the data bits.
                            spi_sck <= 1'b1;
                            if (bit_idx >= DATA_BIT0) begin
                                rx_sr <= {rx_sr[14:0], spi_miso};
                            end
                        end else begin
                            // End of high half: drop SCK and advance MOSI, or close the frame.
                            spi_sck <= 1'b0;
                            if (bit_idx == LAST_BIT) begin
                                spi_cs_n <= 1'b1;
                                spi_mosi <= 1'b0;
                                state    <= ST_HOLD;
                            end else begin
                                bit_idx  <= bit_idx + 6'd1;
                                tx_sr    <= {tx_sr[46:0], 1'b0};
                                spi_mosi <= tx_sr[46];
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    if (!we_q) begin
                        rdata_q  <= rx_sr;
                        rvalid_q <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
